ysyx_23060124_pc_seq: RTL and testbench

//  Multi-cycle sequencer for the PC register and instruction fetch. Owns the PC, issues one

---
 rtl/ysyx_23060124_pc_seq.sv | 164 ++++++++++++++++
 tb/tb_ysyx_23060124_pc_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060124_pc_seq.sv
// ----------------------------------------------------------------------------
// ysyx_23060124_pc_seq
//   Multi-cycle PC / instruction-fetch sequencer. Owns the PC, issues one
//   fetch per instruction over a valid/ready request/response pair, holds the
//   fetched instruction for decode/execute, then commits the next PC
//   (pc+4 or a redirect target). Fetch bus errors and misaligned targets
//   trap to i_mtvec.
//
// Ports
//   clk, i_rst_pcs             clock, asynchronous active-high reset
//   o_req_valid/i_req_ready    fetch request handshake, o_req_addr = o_pc
//   i_rsp_valid/o_rsp_ready    fetch response handshake, i_rsp_data/i_rsp_err
//   o_inst, o_inst_valid       latched instruction for decode/execute
//   i_exu_done                 execute finished, commit next PC
//   i_redirect, i_redirect_pc  take redirect target instead of pc+4
//   i_halt                     ebreak: stop fetching after this commit
//   i_mtvec                    trap vector for fetch faults
//   o_pc                       current PC
//   o_fault, o_fault_epc       1-cycle fault pulse, faulting PC (held)
//   o_retire_cnt               committed instruction count
// ----------------------------------------------------------------------------
module ysyx_23060124_pc_seq #(
    parameter int unsigned          ISA_WIDTH = 32,
    parameter logic [ISA_WIDTH-1:0] RESET_PC  = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 i_rst_pcs,
    output logic                 o_req_valid,
    input  logic                 i_req_ready,
    output logic [ISA_WIDTH-1:0] o_req_addr,
    input  logic                 i_rsp_valid,
    output logic                 o_rsp_ready,
    input  logic [ISA_WIDTH-1:0] i_rsp_data,
    input  logic                 i_rsp_err,
    output logic [ISA_WIDTH-1:0] o_inst,
    output logic                 o_inst_valid,
    input  logic                 i_exu_done,
    input  logic                 i_redirect,
    input  logic [ISA_WIDTH-1:0] i_redirect_pc,
    input  logic                 i_halt,
    input  logic [ISA_WIDTH-1:0] i_mtvec,
    output logic [ISA_WIDTH-1:0] o_pc,
    output logic                 o_fault,
    output logic [ISA_WIDTH-1:0] o_fault_epc,
    output logic [63:0]          o_retire_cnt
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_EXEC = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam logic [ISA_WIDTH-1:0] PC_STEP = ISA_WIDTH'(4);

    state_t               state, state_nxt;
    logic [ISA_WIDTH-1:0] target;
    logic                 rsp_ok;      // good response accepted in WAIT
    logic                 rsp_fault;   // errored response accepted in WAIT
    logic                 commit;      // aligned target committed in EXEC
    logic                 tgt_fault;   // misaligned target in EXEC

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge i_rst_pcs) begin
        if (i_rst_pcs) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        o_req_valid = 1'b0;
        o_rsp_ready = 1'b0;
        rsp_ok      = 1'b0;
        rsp_fault   = 1'b0;
        commit      = 1'b0;
        tgt_fault   = 1'b0;
        target      = i_redirect ? i_redirect_pc : (o_pc + PC_STEP);

        unique case (state)
            S_REQ: begin
                o_req_valid = 1'b1;
                if (i_req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                o_rsp_ready = 1'b1;
                if (i_rsp_valid) begin
                    if (i_rsp_err) begin
                        rsp_fault = 1'b1;
                        state_nxt = S_REQ;
                    end else begin
                        rsp_ok    = 1'b1;
                        state_nxt = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (i_exu_done) begin
                    // A misaligned target traps even when halting: the trap
                    // handler must run, so the halt request is dropped.
                    if (target[1:0] != 2'b00) begin
                        tgt_fault = 1'b1;
                        state_nxt = S_REQ;
                    end else begin
                        commit    = 1'b1;
                        state_nxt = i_halt ? S_HALT : S_REQ;
                    end
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_REQ;
            end
        endcase
    end

    assign o_req_addr = o_pc;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge i_rst_pcs) begin
        if (i_rst_pcs) begin
            o_pc         <= RESET_PC;
            o_inst       <= '0;
            o_inst_valid <= 1'b0;
            o_fault      <= 1'b0;
            o_fault_epc  <= '0;
            o_retire_cnt <= '0;
        end else begin
            o_fault <= rsp_fault | tgt_fault;

            if (rsp_ok) begin
                o_inst       <= i_rsp_data;
                o_inst_valid <= 1'b1;
            end

            if (rsp_fault || tgt_fault) begin
                o_fault_epc <= o_pc;
                o_pc        <= i_mtvec;
            end else if (commit) begin
                o_pc         <= target;
                o_retire_cnt <= o_retire_cnt + 64'd1;
            end

            if (commit || tgt_fault) begin
                o_inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060124_pc_seq.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060124_pc_seq
//   Directed bench for ysyx_23060124_pc_seq: sequential fetch, request
//   back-pressure, redirect, misaligned-target trap, fetch bus error,
//   halt and asynchronous reset in the middle of a fetch.
// ----------------------------------------------------------------------------
module tb_ysyx_23060124_pc_seq;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] MTVEC  = 32'h8000_0800;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic [31:0] inst;
    logic        inst_valid;
    logic        exu_done, redirect, halt;
    logic [31:0] redirect_pc, mtvec;
    logic [31:0] pc;
    logic        fault;
    logic [31:0] fault_epc;
    logic [63:0] retire_cnt;

    int unsigned n_vec;
    int unsigned n_err;

    ysyx_23060124_pc_seq #(
        .ISA_WIDTH(32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk          (clk),
        .i_rst_pcs    (rst),
        .o_req_valid  (req_valid),
        .i_req_ready  (req_ready),
        .o_req_addr   (req_addr),
        .i_rsp_valid  (rsp_valid),
        .o_rsp_ready  (rsp_ready),
        .i_rsp_data   (rsp_data),
        .i_rsp_err    (rsp_err),
        .o_inst       (inst),
        .o_inst_valid (inst_valid),
        .i_exu_done   (exu_done),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .i_halt       (halt),
        .i_mtvec      (mtvec),
        .o_pc         (pc),
        .o_fault      (fault),
        .o_fault_epc  (fault_epc),
        .o_retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one clock; outputs are sampled and inputs driven 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_err     = 1'b0;
        rsp_data    = NOP;
        exu_done    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        halt        = 1'b0;
        mtvec       = MTVEC;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        check("rst_req_valid",  64'(req_valid),  64'd1);
        check("rst_pc",         64'(pc),         64'h8000_0000);
        check("rst_inst",       64'(inst),       64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_fault",      64'(fault),      64'd0);
        check("rst_epc",        64'(fault_epc),  64'd0);
        check("rst_cnt",        retire_cnt,      64'd0);

        // 1: zero-wait memory, done every EXEC -> 3 cycles per instruction
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        exu_done  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("seq_req_valid", 64'(req_valid), 64'd1);
            check("seq_req_addr",  64'(req_addr),  64'(RST_PC + 32'(4 * i)));
            check("seq_cnt",       retire_cnt,     64'(i));
            tick();
            check("seq_rsp_ready", 64'(rsp_ready), 64'd1);
            check("seq_no_req",    64'(req_valid), 64'd0);
            tick();
            check("seq_inst_valid", 64'(inst_valid), 64'd1);
            check("seq_inst",       64'(inst),       64'(NOP));
            tick();
        end
        check("seq_end_pc",  64'(pc),    64'h8000_000C);
        check("seq_end_cnt", retire_cnt, 64'd3);

        // 2: request back-pressure holds the request and the state
        req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_req_valid", 64'(req_valid), 64'd1);
            check("bp_req_addr",  64'(req_addr),  64'h8000_000C);
            check("bp_rsp_ready", 64'(rsp_ready), 64'd0);
        end
        req_ready = 1'b1;
        tick();
        check("bp_wait", 64'(rsp_ready), 64'd1);
        tick();
        check("bp_exec", 64'(inst_valid), 64'd1);

        // 3: redirect to an aligned target
        redirect    = 1'b1;
        redirect_pc = 32'h8000_1000;
        tick();
        check("redir_addr", 64'(req_addr), 64'h8000_1000);
        check("redir_cnt",  retire_cnt,    64'd4);
        check("redir_iv",   64'(inst_valid), 64'd0);

        // 4: misaligned redirect target traps to mtvec, not counted
        redirect_pc = 32'h8000_0102;
        tick();
        tick();
        tick();
        check("mis_fault", 64'(fault),     64'd1);
        check("mis_epc",   64'(fault_epc), 64'h8000_1000);
        check("mis_pc",    64'(pc),        64'(MTVEC));
        check("mis_cnt",   retire_cnt,     64'd4);
        check("mis_req",   64'(req_valid), 64'd1);
        redirect_pc = 32'h8000_0010;
        tick();
        check("mis_pulse", 64'(fault),     64'd0);
        check("mis_epc_hold", 64'(fault_epc), 64'h8000_1000);
        tick();
        tick();
        check("mis_recover_pc",  64'(pc),    64'h8000_0010);
        check("mis_recover_cnt", retire_cnt, 64'd5);

        // 5: bus error on the response at pc 0x80000010
        rsp_err = 1'b1;
        tick();
        tick();
        check("err_fault", 64'(fault),      64'd1);
        check("err_epc",   64'(fault_epc),  64'h8000_0010);
        check("err_iv",    64'(inst_valid), 64'd0);
        check("err_pc",    64'(pc),         64'(MTVEC));
        check("err_req",   64'(req_addr),   64'(MTVEC));
        check("err_cnt",   retire_cnt,      64'd5);
        rsp_err = 1'b0;
        tick();
        check("err_pulse", 64'(fault), 64'd0);

        // 6: done+halt commits pc+4 then stops fetching
        redirect = 1'b0;
        halt     = 1'b1;
        tick();
        tick();
        check("halt_pc",  64'(pc),         64'(MTVEC + 32'd4));
        check("halt_cnt", retire_cnt,      64'd6);
        check("halt_iv",  64'(inst_valid), 64'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("halt_no_req", 64'(req_valid), 64'd0);
            check("halt_pc_frz", 64'(pc),        64'(MTVEC + 32'd4));
        end
        halt = 1'b0;

        // reset in the middle of a fetch
        rst = 1'b1;
        #1;
        rst       = 1'b0;
        rsp_valid = 1'b0;
        tick();
        tick();
        check("mid_wait", 64'(rsp_ready), 64'd1);
        rst = 1'b1;
        #1;
        check("arst_pc",  64'(pc),        64'(RST_PC));
        check("arst_req", 64'(req_valid), 64'd1);
        check("arst_cnt", retire_cnt,     64'd0);
        rst       = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        tick();
        check("late_rsp_ready", 64'(rsp_ready),  64'd0);
        check("late_rsp_iv",    64'(inst_valid), 64'd0);
        check("late_rsp_req",   64'(req_valid),  64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
